// File: rtl/fft_spectrum_peak_hold.sv
`default_nettype none
// ============================================================================
// Module   : fft_spectrum_peak_hold
// Purpose  : FFT bin magnitude, per-bin peak hold with decay, spectrum dpram
//            writer and per-frame peak reporter.
//            Optional macro FFT_PEAK_HOLD_FREEZE_EN adds i_freeze.
// Revision : 1.0 - initial release
// ============================================================================
module fft_spectrum_peak_hold #(
    parameter int NPOINT      = 1024,
    parameter int DOUT_W      = 8,
    parameter int MAG_W       = 16,
    parameter int DECAY_SHIFT = 4,
    localparam int c_AW       = $clog2(NPOINT / 2)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     s_tvalid,
    input  logic                     s_tlast,
    input  logic signed [DOUT_W-1:0] s_tdata_re,
    input  logic signed [DOUT_W-1:0] s_tdata_im,
`ifdef FFT_PEAK_HOLD_FREEZE_EN
    input  logic                     i_freeze,
`endif
    output logic [c_AW-1:0]          ram_addr_a,
    output logic [MAG_W-1:0]         ram_din_a,
    output logic                     ram_we_a,
    output logic                     o_frame_done,
    output logic [c_AW-1:0]          o_peak_bin,
    output logic [MAG_W-1:0]         o_peak_mag,
    output logic                     o_frame_err
);

    localparam int                c_KW        = $clog2(NPOINT);
    localparam int                c_HALF      = NPOINT / 2;
    localparam logic [c_AW-1:0]   c_LAST_BIN  = c_AW'(c_HALF - 1);
    localparam logic [c_KW-1:0]   c_LAST_BEAT = c_KW'(NPOINT - 1);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_SYNC  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_KW-1:0]   r_cnt;
    logic [c_AW-1:0]   r_clr_cnt;

    logic              w_beat;
    logic              w_at_end;
    logic              w_err_early;
    logic              w_err_late;
    logic              w_store;
    logic [c_AW-1:0]   w_k;
    logic              w_frz_beat;

    assign w_beat      = (r_state == ST_RUN) && s_tvalid;
    assign w_at_end    = (r_cnt == c_LAST_BEAT);
    assign w_err_early = w_beat && s_tlast && !w_at_end;
    assign w_err_late  = w_beat && !s_tlast && w_at_end;
    assign w_store     = w_beat && !r_cnt[c_KW-1];
    assign w_k         = r_cnt[c_AW-1:0];

    // ---------------- control FSM ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_CLEAR: if (r_clr_cnt == c_LAST_BIN) w_state_nxt = ST_SYNC;
            ST_SYNC:  if (s_tvalid && s_tlast) w_state_nxt = ST_RUN;
            ST_RUN:   if (w_err_late) w_state_nxt = ST_SYNC;
            default:  w_state_nxt = ST_CLEAR;
        endcase
    end

    // Any tlast, legal or early, restarts the bin count at 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_clr_cnt <= '0;
        end else begin
            if (r_state == ST_CLEAR) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
            if (r_state != ST_RUN) begin
                r_cnt <= '0;
            end else if (s_tvalid) begin
                r_cnt <= s_tlast ? '0 : r_cnt + 1'b1;
            end
        end
    end

`ifdef FFT_PEAK_HOLD_FREEZE_EN
    logic r_frz_frame;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_frz_frame <= 1'b0;
        end else if (w_beat && (r_cnt == '0)) begin
            r_frz_frame <= i_freeze;
        end
    end

    // Bin 0 uses the live pin so its own write obeys the new setting.
    assign w_frz_beat = (r_cnt == '0) ? i_freeze : r_frz_frame;
`else
    assign w_frz_beat = 1'b0;
`endif

    // ---------------- stage 1: magnitude ----------------
    logic [DOUT_W-1:0] w_abs_re;
    logic [DOUT_W-1:0] w_abs_im;
    logic [DOUT_W-1:0] w_max;
    logic [DOUT_W-1:0] w_min;
    logic [DOUT_W:0]   w_mag;

    assign w_abs_re = s_tdata_re[DOUT_W-1] ? DOUT_W'(-s_tdata_re) : DOUT_W'(s_tdata_re);
    assign w_abs_im = s_tdata_im[DOUT_W-1] ? DOUT_W'(-s_tdata_im) : DOUT_W'(s_tdata_im);
    assign w_max    = (w_abs_re >= w_abs_im) ? w_abs_re : w_abs_im;
    assign w_min    = (w_abs_re >= w_abs_im) ? w_abs_im : w_abs_re;
    assign w_mag    = {1'b0, w_max} + {2'b00, w_min[DOUT_W-1:1]};

    logic              r_s1_valid;
    logic              r_s1_frz;
    logic [c_AW-1:0]   r_s1_k;
    logic [MAG_W-1:0]  r_s1_mag;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_frz   <= 1'b0;
            r_s1_k     <= '0;
            r_s1_mag   <= '0;
        end else begin
            r_s1_valid <= w_store;
            r_s1_frz   <= w_frz_beat;
            r_s1_k     <= w_k;
            r_s1_mag   <= MAG_W'(w_mag);
        end
    end

    // ---------------- hold memory ----------------
    logic [MAG_W-1:0]  r_hold [c_HALF];
    logic [MAG_W-1:0]  r_old;
    logic              w_hold_we;
    logic [c_AW-1:0]   w_hold_addr;
    logic [MAG_W-1:0]  w_hold_din;
    logic [MAG_W-1:0]  w_new;

    assign w_hold_we   = !i_rst && ((r_state == ST_CLEAR) || (r_s1_valid && !r_s1_frz));
    assign w_hold_addr = (r_state == ST_CLEAR) ? r_clr_cnt : r_s1_k;
    assign w_hold_din  = (r_state == ST_CLEAR) ? '0 : w_new;

    always_ff @(posedge i_clk) begin
        if (w_hold_we) begin
            r_hold[w_hold_addr] <= w_hold_din;
        end
        r_old <= r_hold[w_k];
    end

    // ---------------- stage 2: peak hold update ----------------
    assign w_new = (r_s1_mag >= r_old) ? r_s1_mag : (r_old - (r_old >> DECAY_SHIFT));

    logic              r_we;
    logic [c_AW-1:0]   r_addr;
    logic [MAG_W-1:0]  r_din;
    logic [c_AW-1:0]   r_run_bin;
    logic [MAG_W-1:0]  r_run_mag;
    logic              r_done_pend;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_din       <= '0;
            r_run_bin   <= '0;
            r_run_mag   <= '0;
            r_done_pend <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (r_state == ST_CLEAR) begin
                r_we   <= 1'b1;
                r_addr <= r_clr_cnt;
                r_din  <= '0;
            end else if (r_s1_valid && !r_s1_frz) begin
                r_we   <= 1'b1;
                r_addr <= r_s1_k;
                r_din  <= w_new;
            end
            // Bin 1 seeds the search so an all-zero frame reports bin 1; DC never competes.
            if (r_s1_valid) begin
                if (r_s1_k == c_AW'(1)) begin
                    r_run_bin <= r_s1_k;
                    r_run_mag <= w_new;
                end else if ((r_s1_k != '0) && (w_new > r_run_mag)) begin
                    r_run_bin <= r_s1_k;
                    r_run_mag <= w_new;
                end
            end
            r_done_pend <= r_s1_valid && (r_s1_k == c_LAST_BIN);
        end
    end

    // ---------------- stage 3: frame report ----------------
    logic              r_done;
    logic              r_err;
    logic [c_AW-1:0]   r_pk_bin;
    logic [MAG_W-1:0]  r_pk_mag;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_pk_bin <= '0;
            r_pk_mag <= '0;
        end else begin
            r_done <= r_done_pend;
            r_err  <= w_err_early || w_err_late;
            if (r_done_pend) begin
                r_pk_bin <= r_run_bin;
                r_pk_mag <= r_run_mag;
            end
        end
    end

    assign ram_we_a     = r_we;
    assign ram_addr_a   = r_addr;
    assign ram_din_a    = r_din;
    assign o_frame_done = r_done;
    assign o_frame_err  = r_err;
    assign o_peak_bin   = r_pk_bin;
    assign o_peak_mag   = r_pk_mag;

endmodule
`default_nettype wire

// File: tb/tb_fft_spectrum_peak_hold.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_spectrum_peak_hold
// Purpose  : Scoreboard bench for fft_spectrum_peak_hold (NPOINT=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_spectrum_peak_hold;

    localparam int NPOINT      = 16;
    localparam int DOUT_W      = 8;
    localparam int MAG_W       = 16;
    localparam int DECAY_SHIFT = 2;
    localparam int AW          = 3;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     tvalid = 1'b0;
    logic                     tlast = 1'b0;
    logic signed [DOUT_W-1:0] re = '0;
    logic signed [DOUT_W-1:0] im = '0;
    logic                     freeze = 1'b0;
    logic [AW-1:0]            ram_addr_a;
    logic [MAG_W-1:0]         ram_din_a;
    logic                     ram_we_a;
    logic                     frame_done;
    logic [AW-1:0]            peak_bin;
    logic [MAG_W-1:0]         peak_mag;
    logic                     frame_err;

    fft_spectrum_peak_hold #(
        .NPOINT      (NPOINT),
        .DOUT_W      (DOUT_W),
        .MAG_W       (MAG_W),
        .DECAY_SHIFT (DECAY_SHIFT)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .s_tvalid     (tvalid),
        .s_tlast      (tlast),
        .s_tdata_re   (re),
        .s_tdata_im   (im),
`ifdef FFT_PEAK_HOLD_FREEZE_EN
        .i_freeze     (freeze),
`endif
        .ram_addr_a   (ram_addr_a),
        .ram_din_a    (ram_din_a),
        .ram_we_a     (ram_we_a),
        .o_frame_done (frame_done),
        .o_peak_bin   (peak_bin),
        .o_peak_mag   (peak_mag),
        .o_frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int addr; int din; int at;} wr_t;
    typedef struct {int bin; int mag; int at;} done_t;

    wr_t   wr_q[$];
    done_t done_q[$];
    int    err_q[$];
    int    hold[8];
    int    fre[16];
    int    fim[16];
    int    checks = 0;
    int    errors = 0;

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        wr_t   ew;
        done_t ed;
        int    ee;
        if (ram_we_a) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL write: unexpected addr=%0d din=%0d cycle=%0d", ram_addr_a, ram_din_a, cyc);
            end else begin
                ew = wr_q.pop_front();
                if (int'(ram_addr_a) != ew.addr || int'(ram_din_a) != ew.din || cyc != ew.at) begin
                    errors++;
                    $display("FAIL write: got addr=%0d din=%0d cycle=%0d, expected addr=%0d din=%0d cycle=%0d",
                             ram_addr_a, ram_din_a, cyc, ew.addr, ew.din, ew.at);
                end
            end
        end
        if (frame_done) begin
            checks++;
            if (done_q.size() == 0) begin
                errors++;
                $display("FAIL done: unexpected pulse bin=%0d mag=%0d cycle=%0d", peak_bin, peak_mag, cyc);
            end else begin
                ed = done_q.pop_front();
                if (int'(peak_bin) != ed.bin || int'(peak_mag) != ed.mag || cyc != ed.at) begin
                    errors++;
                    $display("FAIL done: got bin=%0d mag=%0d cycle=%0d, expected bin=%0d mag=%0d cycle=%0d",
                             peak_bin, peak_mag, cyc, ed.bin, ed.mag, ed.at);
                end
            end
        end
        if (frame_err) begin
            checks++;
            if (err_q.size() == 0) begin
                errors++;
                $display("FAIL frame_err: unexpected pulse cycle=%0d", cyc);
            end else begin
                ee = err_q.pop_front();
                if (cyc != ee) begin
                    errors++;
                    $display("FAIL frame_err: got cycle=%0d, expected cycle=%0d", cyc, ee);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            tvalid = 1'b0;
            tlast  = 1'b0;
        end
    endtask

    task automatic beat(input bit v, input bit l, input int r, input int i, input bit fz_pin,
                        input int bin, input bit frz_frame, input bit err);
        int  a;
        int  b;
        int  m;
        int  nv;
        wr_t w;
        @(negedge clk);
        tvalid = v;
        tlast  = l;
        re     = DOUT_W'(r);
        im     = DOUT_W'(i);
        freeze = fz_pin;
        if (err) err_q.push_back(cyc + 1);
        if (bin >= 0) begin
            a  = iabs(r);
            b  = iabs(i);
            m  = (a >= b) ? a + b / 2 : b + a / 2;
            nv = (m >= hold[bin]) ? m : hold[bin] - hold[bin] / 4;
            if (!frz_frame) begin
                hold[bin] = nv;
                w.addr = bin;
                w.din  = nv;
                w.at   = cyc + 2;
                wr_q.push_back(w);
            end
        end
    endtask

    // n beats from bin 0; tlast on the final beat if last_final.
    task automatic frame(input int n, input bit last_final, input bit frz,
                         input int pk_bin, input int pk_mag, input int gap_after);
        bit    l;
        bit    e;
        done_t d;
        for (int k = 0; k < n; k++) begin
            l = last_final && (k == n - 1);
            e = (l && k != NPOINT - 1) || (!l && k == NPOINT - 1);
            beat(1'b1, l, fre[k], fim[k], (k == 0) ? frz : !frz, (k < 8) ? k : -1, frz, e);
            if (k == 7) begin
                d.bin = pk_bin;
                d.mag = pk_mag;
                d.at  = cyc + 3;
                done_q.push_back(d);
            end
            if (k == gap_after) idle(1);
        end
    endtask

    task automatic zero_data();
        for (int k = 0; k < 16; k++) begin
            fre[k] = 0;
            fim[k] = 0;
        end
    endtask

    initial begin
        wr_t w;
        int  m;
        for (int k = 0; k < 8; k++) hold[k] = 0;
        zero_data();

        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ram_we_a || ram_addr_a != 0 || ram_din_a != 0 || frame_done || peak_bin != 0 ||
            peak_mag != 0 || frame_err) begin
            errors++;
            $display("FAIL reset_outputs: we=%0d addr=%0d din=%0d done=%0d bin=%0d mag=%0d err=%0d, expected all 0",
                     ram_we_a, ram_addr_a, ram_din_a, frame_done, peak_bin, peak_mag, frame_err);
        end
        m   = cyc;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w.addr = i;
            w.din  = 0;
            w.at   = m + 1 + i;
            wr_q.push_back(w);
        end
        // Beats during CLEAR must be ignored, tlast included.
        for (int k = 0; k < 7; k++) beat(1'b1, k[0], 50, 50, 1'b0, -1, 1'b0, 1'b0);
        idle(2);
        beat(1'b1, 1'b0, 10, 10, 1'b0, -1, 1'b0, 1'b0);
        beat(1'b1, 1'b1, 10, 10, 1'b0, -1, 1'b0, 1'b0);

        frame(16, 1'b1, 1'b0, 1, 0, -1);                 // all zero -> bin 1, mag 0
        fre[3] = 100; fim[3] = -40;
        frame(16, 1'b1, 1'b0, 3, 120, -1);
        zero_data(); fre[0] = 127;
        frame(16, 1'b1, 1'b0, 3, 90, -1);                // DC excluded from peak
        zero_data();
        frame(16, 1'b1, 1'b0, 3, 68, -1);
        frame(16, 1'b1, 1'b0, 3, 51, -1);
        fre[5] = -128; fim[5] = -128;
        frame(16, 1'b1, 1'b0, 5, 192, 3);                // idle gap after bin 3
        zero_data();
        fre[2] = -128; fim[2] = -128; fre[6] = -128; fim[6] = -128;
        frame(16, 1'b1, 1'b0, 2, 192, -1);               // tie -> lower bin
        zero_data();
        frame(11, 1'b1, 1'b0, 2, 144, -1);               // early tlast on beat 10
        frame(16, 1'b1, 1'b0, 2, 108, -1);
        frame(6, 1'b1, 1'b0, 0, 0, -1);                  // early tlast at k=5: no done
        frame(16, 1'b1, 1'b0, 6, 81, -1);
        frame(16, 1'b0, 1'b0, 6, 61, -1);                // missing tlast -> SYNC
        for (int k = 0; k < 3; k++) beat(1'b1, 1'b0, 90, 0, 1'b0, -1, 1'b0, 1'b0);
        beat(1'b1, 1'b1, 90, 0, 1'b0, -1, 1'b0, 1'b0);
        frame(16, 1'b1, 1'b0, 6, 46, -1);
`ifdef FFT_PEAK_HOLD_FREEZE_EN
        fre[4] = 100;
        frame(16, 1'b1, 1'b1, 4, 100, -1);               // frozen frame: no writes
        zero_data();
        frame(16, 1'b1, 1'b0, 6, 35, -1);
`endif
        idle(6);
        for (int c = 0; c < 20 && (wr_q.size() + done_q.size() + err_q.size()) != 0; c++) idle(1);
        while (wr_q.size() != 0) begin
            w = wr_q.pop_front();
            checks++; errors++;
            $display("FAIL write: missing addr=%0d din=%0d expected at cycle=%0d", w.addr, w.din, w.at);
        end
        while (done_q.size() != 0) begin
            void'(done_q.pop_front());
            checks++; errors++;
            $display("FAIL done: expected pulse never seen");
        end
        while (err_q.size() != 0) begin
            void'(err_q.pop_front());
            checks++; errors++;
            $display("FAIL frame_err: expected pulse never seen");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
